// File: rtl/spi_slave.sv
// Receive-only SPI slave: shifts MSB-first serial bits into BITS_PER_PIXEL-bit
// words and raises pixel_clk for one spi_clk period as each word completes.
module spi_slave #(
  parameter int BITS_PER_PIXEL = 32
) (
  input  logic                      spi_clk,
  input  logic                      reset,
  input  logic                      spi_mosi,
  output logic [BITS_PER_PIXEL-1:0] data,
  output logic                      pixel_clk
);

  localparam int CW = $clog2(BITS_PER_PIXEL);
  localparam logic [CW-1:0] LAST_BIT = CW'(BITS_PER_PIXEL - 1);

  logic [BITS_PER_PIXEL-2:0] shift_reg;
  logic [BITS_PER_PIXEL-2:0] shift_next;
  logic [CW-1:0]             count_reg;

  // A 2-bit word keeps a single pending bit, so there is nothing to shift along.
  generate
    if (BITS_PER_PIXEL == 2) begin : g_shift_one
      assign shift_next = spi_mosi;
    end else begin : g_shift_many
      assign shift_next = {shift_reg[BITS_PER_PIXEL-3:0], spi_mosi};
    end
  endgenerate

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      shift_reg <= '0;
      data      <= '0;
      pixel_clk <= 1'b0;
    end else if (count_reg == LAST_BIT) begin
      // The last bit goes straight into data so data and strobe rise together.
      data      <= {shift_reg, spi_mosi};
      pixel_clk <= 1'b1;
      count_reg <= '0;
      shift_reg <= '0;
    end else begin
      shift_reg <= shift_next;
      count_reg <= count_reg + 1'b1;
      pixel_clk <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: 32- and 16-bit instances share one serial
// stream and are checked every edge against a bit-history model plus vector tables.
module tb_spi_slave;

  logic        spi_clk  = 1'b0;
  logic        reset    = 1'b1;
  logic        spi_mosi = 1'b0;
  logic [31:0] data32;
  logic        pclk32;
  logic [15:0] data16;
  logic        pclk16;

  spi_slave #(.BITS_PER_PIXEL(32)) dut32 (
    .spi_clk(spi_clk), .reset(reset), .spi_mosi(spi_mosi),
    .data(data32), .pixel_clk(pclk32)
  );

  spi_slave #(.BITS_PER_PIXEL(16)) dut16 (
    .spi_clk(spi_clk), .reset(reset), .spi_mosi(spi_mosi),
    .data(data16), .pixel_clk(pclk16)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          hist[$];       // every bit clocked in since the last reset
  logic [31:0] cap32[$];      // data seen at each pixel_clk rising edge
  logic [15:0] cap16[$];

  always @(posedge pclk32) begin
    #1;
    cap32.push_back(data32);
  end

  always @(posedge pclk16) begin
    #1;
    cap16.push_back(data16);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Last complete word of the history: words are consecutive bpp-bit slices from reset.
  function automatic logic [31:0] model_word(input int bpp);
    int n;
    logic [31:0] w;
    n = (hist.size() / bpp) * bpp;
    w = '0;
    if (n == 0) return w;
    for (int i = n - bpp; i < n; i++) w = {w[30:0], hist[i]};
    return w;
  endfunction

  function automatic logic model_strobe(input int bpp);
    return (hist.size() > 0) && (hist.size() % bpp == 0);
  endfunction

  task automatic send_bit(input bit b);
    spi_mosi = b;
    #5 spi_clk = 1'b1;
    #1;
    hist.push_back(b);
    chk("edge_data32", data32, model_word(32));
    chk("edge_pclk32", 32'(pclk32), 32'(model_strobe(32)));
    chk("edge_data16", 32'(data16), model_word(16));
    chk("edge_pclk16", 32'(pclk16), 32'(model_strobe(16)));
    #4 spi_clk = 1'b0;
  endtask

  task automatic send_range(input logic [31:0] w, input int msb, input int lsb);
    for (int i = msb; i >= lsb; i--) send_bit(w[i]);
  endtask

  // Reset is raised while spi_clk is low, so its effect must be seen without any edge.
  task automatic do_reset();
    #1 reset = 1'b1;
    #2;
    chk("rst_data32", data32, 32'h0);
    chk("rst_pclk32", 32'(pclk32), 32'h0);
    chk("rst_data16", 32'(data16), 32'h0);
    chk("rst_pclk16", 32'(pclk16), 32'h0);
    #2 reset = 1'b0;
    hist.delete();
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp32;
    logic [15:0] exp16_hi;
    logic [15:0] exp16_lo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c32;
    int c16;

    vecs[0] = '{32'hd0e0a0d0, 32'hd0e0a0d0, 16'hd0e0, 16'ha0d0};
    vecs[1] = '{32'hb0e0e0f0, 32'hb0e0e0f0, 16'hb0e0, 16'he0f0};
    vecs[2] = '{32'h00000000, 32'h00000000, 16'h0000, 16'h0000};
    vecs[3] = '{32'hffffffff, 32'hffffffff, 16'hffff, 16'hffff};
    vecs[4] = '{32'h00000000, 32'h00000000, 16'h0000, 16'h0000};
    vecs[5] = '{32'h80000001, 32'h80000001, 16'h8000, 16'h0001};

    #3;
    do_reset();

    // Back-to-back stream: the 96-bit plan pattern followed by the alternating words.
    for (int i = 0; i < 6; i++) begin
      c32 = cap32.size();
      c16 = cap16.size();
      send_range(vecs[i].word, 31, 0);
      chk("tbl_strobes32", 32'(cap32.size() - c32), 32'd1);
      chk("tbl_strobes16", 32'(cap16.size() - c16), 32'd2);
      if (cap32.size() >= 1 && cap16.size() >= 2) begin
        chk("tbl_word32", cap32[cap32.size()-1], vecs[i].exp32);
        chk("tbl_word16_hi", 32'(cap16[cap16.size()-2]), 32'(vecs[i].exp16_hi));
        chk("tbl_word16_lo", 32'(cap16[cap16.size()-1]), 32'(vecs[i].exp16_lo));
      end
      $display("vector %0d: sent %h, data32 %h", i, vecs[i].word, data32);
    end

    // 31 ones give no strobe; the 32nd completes the word; the 33rd drops the strobe.
    do_reset();
    c32 = cap32.size();
    send_range(32'hffffffff, 31, 1);
    chk("ones31_strobes", 32'(cap32.size() - c32), 32'd0);
    chk("ones31_data", data32, 32'h0);
    send_bit(1'b1);
    chk("ones32_data", data32, 32'hffffffff);
    chk("ones32_pclk", 32'(pclk32), 32'd1);
    send_bit(1'b0);
    chk("ones33_pclk", 32'(pclk32), 32'd0);
    chk("ones33_data", data32, 32'hffffffff);
    $display("ones sequence: data32 %h", data32);

    // Reset mid-word discards the partial word.
    do_reset();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
    do_reset();
    c32 = cap32.size();
    send_range(32'h12345678, 31, 0);
    chk("midrst_strobes", 32'(cap32.size() - c32), 32'd1);
    if (cap32.size() > c32) chk("midrst_word", cap32[cap32.size()-1], 32'h12345678);
    $display("mid-word reset: data32 %h", data32);

    // Clock pause after bit 20 holds state with no strobe.
    do_reset();
    c32 = cap32.size();
    send_range(32'ha5a5a5a5, 31, 12);
    #1000;
    chk("pause_strobes", 32'(cap32.size() - c32), 32'd0);
    chk("pause_pclk", 32'(pclk32), 32'd0);
    send_range(32'ha5a5a5a5, 11, 0);
    chk("resume_strobes", 32'(cap32.size() - c32), 32'd1);
    if (cap32.size() > c32) chk("resume_word", cap32[cap32.size()-1], 32'ha5a5a5a5);
    $display("pause sequence: data32 %h", data32);

    // Reset while pixel_clk is still high (do_reset checks it drops at once).
    chk("pre_rst_pclk", 32'(pclk32), 32'd1);
    do_reset();

    // Random stream with random pauses and occasional resets, checked by the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) #($urandom_range(20, 200));
      if ($urandom_range(0, 199) == 0) do_reset();
      send_bit(1'($urandom_range(0, 1)));
    end
    $display("random stream: %0d bits since last reset, data32 %h", hist.size(), data32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Receive-only SPI slave (mode 0 style: MOSI sampled on rising spi_clk, MSB first, no chip-select).
- Assembles each BITS_PER_PIXEL-bit serial word into a parallel pixel word.
- Presents the word on data and issues a one-SPI-clock-period strobe on pixel_clk.
- Sits at the front of the HUB75 controller and feeds pixel words to the framebuffer/write logic, which captures data on the rising edge of pixel_clk.

Parameters:
- BITS_PER_PIXEL, default 32: word width in bits. Legal range is 2 or more. Typical values are 16 and 32.

Ports:
- spi_clk, input, 1: SPI serial clock and the block's only clock. All state changes on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- spi_mosi, input, 1: serial data in, MSB first, sampled on rising spi_clk.
- data, output, BITS_PER_PIXEL: last complete received word.
- pixel_clk, output, 1: word-ready strobe. data is valid and stable at its rising edge.

Behaviour:
- Reset is asynchronous and active-high and is the only reset. While reset=1:
  - bit counter = 0
  - shift register = 0
  - data = 0
  - pixel_clk = 0
- Internal state:
  - shift register, BITS_PER_PIXEL-1 bits wide (holds the bits received so far)
  - bit counter, clog2(BITS_PER_PIXEL) bits wide, range 0..BITS_PER_PIXEL-1
- On each rising spi_clk (reset=0):
  - If counter < BITS_PER_PIXEL-1:
    - shift <= {shift[BPP-3:0], spi_mosi}
    - counter <= counter+1
    - pixel_clk <= 0
  - If counter == BITS_PER_PIXEL-1:
    - data <= {shift[BPP-2:0], spi_mosi}; the first-received bit lands in data[BPP-1]
    - pixel_clk <= 1
    - counter <= 0
    - shift <= 0
- Latency: data and pixel_clk update on the same rising edge that samples the last bit of the word. They are therefore consistent at the pixel_clk rising edge, with no additional delay.
- pixel_clk is high for exactly one spi_clk period, from the last-bit edge until the next rising edge (the first bit of the next word). With BITS_PER_PIXEL >= 2, it is guaranteed low between consecutive back-to-back words.
- data holds its value until the next word completes; it never shows partial words.
- spi_clk stops mid-word: state is held indefinitely, with no timeout. The word completes when clocking resumes.
- spi_clk stops right after a word: pixel_clk stays high until the next rising edge or reset.
- Reset mid-word: the partial word is discarded, data is cleared to 0, and the next bit after reset is bit 0 (MSB) of a new word.
- Reset asserted while pixel_clk=1: pixel_clk drops immediately (asynchronous).
- Framing is purely by bit count from reset. Resynchronisation is done only via reset.
- Word boundaries carry no gap requirement; words may be streamed back-to-back continuously.

Test Plan:
- BPP=32, reset pulse, then 96 bits 0xd0e0a0d0_b0e0e0f0_00000000 MSB first (mosi set while spi_clk low, clock rises) -> exactly three pixel_clk rising edges, with data = d0e0a0d0, b0e0e0f0, 00000000 in order.
- BPP=16, same 96-bit stream -> six strobes, data = d0e0, a0d0, b0e0, e0f0, 0000, 0000.
- After reset, with no clocks -> data=0, pixel_clk=0. After 31 bits of 0xFFFFFFFF -> no strobe and data still 0. The 32nd edge -> data=ffffffff and pixel_clk=1. The 33rd edge -> pixel_clk=0 and data unchanged.
- Send 10 bits, assert reset asynchronously between clock edges, release, then send 0x12345678 -> single strobe with data=12345678, and data=0 immediately on reset.
- Pause spi_clk for an arbitrary time after bit 20 of 0xa5a5a5a5, then resume -> single strobe with data=a5a5a5a5, and no strobe during the pause.
- Alternating words 0xffffffff, 0x00000000, 0x80000001 back-to-back -> pixel_clk toggles low between strobes, and each captured word is exact (MSB/LSB ordering checked by 0x80000001).
